// File: rtl/sync_pkg.sv
// sync_pkg: shared scenario state encoding, clock rate, default timing constants and a width helper.
package sync_pkg;
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ARMED  = 3'd1,
      DELAY  = 3'd2,
      WINDOW = 3'd3,
      FIRE   = 3'd4,
      BUSY   = 3'd5,
      DONE   = 3'd6,
      FAULT  = 3'd7
   } scenario_state_t;
   localparam int CLOCK_HZ              = 200_000_000;
   localparam int FG_DELAY_DEFAULT      = 1_800_000;
   localparam int WINDOW_DEFAULT        = 20_000;
   localparam int TRIG_WIDTH_DEFAULT    = 20;
   localparam int SHOTS_DEFAULT         = 10;
   localparam int READY_TIMEOUT_DEFAULT = 2_000_000;
   function automatic int max_of(input int a, input int b);
      return a > b ? a : b;
   endfunction
endpackage

// File: rtl/sync_edge_detector.sv
// sync_edge_detector: 2-FF synchronizer plus registered rising-edge pulse.
// Ports: clock, reset_signal (sync, active-high), raw (async input),
//        q (one-clock rise pulse, or the synchronized level when PASS_LEVEL=1).
module sync_edge_detector #(
   parameter bit PASS_LEVEL = 1'b0
) (
   input  logic clock,
   input  logic reset_signal,
   input  logic raw,
   output logic q
);
   logic meta, level, prev, rise;
   always_ff @(posedge clock)
      if (reset_signal) {meta, level, prev, rise} <= '0;
      else begin
         meta  <= raw;
         level <= meta;
         prev  <= level;
         rise  <= level & ~prev;
      end
   assign q = PASS_LEVEL ? level : rise;
endmodule

// File: rtl/sync_trigger_sequencer.sv
// sync_trigger_sequencer: arms on start, aligns to fg, opens a gate window and fires a phase-aligned trigger per shot.
// Ports: clock, reset_signal (sync, active-high); async inputs start_signal, fg_signal,
//        phase_signal, detector_ready; outputs output_trigger (registered pulse),
//        scenario_state (state encoding), counter_out (shots fired), miss_count (saturating).
module sync_trigger_sequencer
   import sync_pkg::*;
#(
   parameter int FG_DELAY_CYCLES = FG_DELAY_DEFAULT,
   parameter int WINDOW_CYCLES   = WINDOW_DEFAULT,
   parameter int TRIG_WIDTH      = TRIG_WIDTH_DEFAULT,
   parameter int SHOTS           = SHOTS_DEFAULT,
   parameter int READY_TIMEOUT   = READY_TIMEOUT_DEFAULT
) (
   input  logic       clock,
   input  logic       reset_signal,
   input  logic       start_signal,
   input  logic       fg_signal,
   input  logic       phase_signal,
   input  logic       detector_ready,
   output logic       output_trigger,
   output logic [2:0] scenario_state,
   output logic [7:0] counter_out,
   output logic [7:0] miss_count
);
   // one down-counter serves delay, window, pulse width and ready timeout
   localparam int CW = $clog2(max_of(max_of(FG_DELAY_CYCLES, WINDOW_CYCLES),
                                     max_of(TRIG_WIDTH, READY_TIMEOUT))) + 1;
   scenario_state_t state;
   logic [CW-1:0] cnt;
   logic start_rise, fg_rise, phase_rise, ready, seen_low;
   sync_edge_detector u_start (.clock(clock), .reset_signal(reset_signal), .raw(start_signal), .q(start_rise));
   sync_edge_detector u_fg    (.clock(clock), .reset_signal(reset_signal), .raw(fg_signal),    .q(fg_rise));
   sync_edge_detector u_phase (.clock(clock), .reset_signal(reset_signal), .raw(phase_signal), .q(phase_rise));
   sync_edge_detector #(.PASS_LEVEL(1'b1)) u_ready (.clock(clock), .reset_signal(reset_signal), .raw(detector_ready), .q(ready));
   always_ff @(posedge clock)
      if (reset_signal) begin
         state          <= IDLE;
         cnt            <= '0;
         output_trigger <= 1'b0;
         counter_out    <= '0;
         miss_count     <= '0;
         seen_low       <= 1'b0;
      end else
         case (state)
            IDLE, DONE, FAULT:
               if (start_rise) begin
                  counter_out <= '0;
                  miss_count  <= '0;
                  state       <= ARMED;
               end
            ARMED:
               if (fg_rise) begin
                  cnt   <= CW'(FG_DELAY_CYCLES - 1);
                  state <= DELAY;
               end
            DELAY:
               if (cnt == '0) begin
                  cnt   <= CW'(WINDOW_CYCLES - 1);
                  state <= WINDOW;
               end else cnt <= cnt - 1'b1;
            WINDOW:
               // a phase edge on the last window clock still wins over expiry
               if (phase_rise && ready) begin
                  output_trigger <= 1'b1;
                  counter_out    <= counter_out + 8'd1;
                  cnt            <= CW'(TRIG_WIDTH - 1);
                  state          <= FIRE;
               end else if (cnt == '0) begin
                  miss_count <= miss_count + {7'd0, ~&miss_count};
                  state      <= ARMED;
               end else cnt <= cnt - 1'b1;
            FIRE:
               if (cnt == '0) begin
                  output_trigger <= 1'b0;
                  cnt            <= CW'(READY_TIMEOUT - 1);
                  seen_low       <= 1'b0;
                  state          <= BUSY;
               end else cnt <= cnt - 1'b1;
            BUSY:
               // recovery only counts once ready has been seen low inside BUSY
               if (seen_low && ready) state <= (counter_out >= 8'(SHOTS)) ? DONE : ARMED;
               else if (cnt == '0) state <= FAULT;
               else begin
                  cnt <= cnt - 1'b1;
                  if (!ready) seen_low <= 1'b1;
               end
            default: state <= IDLE;
         endcase
   assign scenario_state = state;
endmodule

// File: tb/tb_sync_trigger_sequencer.sv
// tb_sync_trigger_sequencer: directed vector table plus hand-written corner sequences for the trigger sequencer.
module tb_sync_trigger_sequencer;
   logic clk = 1'b0;
   logic rst, start, fg, ph_man, ph_gen, ph_en, rdy, phase, trig;
   logic [2:0] st;
   logic [7:0] cnt, miss;
   int checks = 0, failures = 0, cyc = 0, ph_rise_cyc = 0, ph_t = 23;
   typedef struct {int st, fg, ph, rdy, n, s, t, c, m;} vec_t;
   vec_t tbl[18];
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   assign phase = ph_en ? ph_gen : ph_man;
   sync_trigger_sequencer #(
      .FG_DELAY_CYCLES(100), .WINDOW_CYCLES(50), .TRIG_WIDTH(4), .SHOTS(3), .READY_TIMEOUT(1000)
   ) dut (
      .clock(clk), .reset_signal(rst), .start_signal(start), .fg_signal(fg),
      .phase_signal(phase), .detector_ready(rdy), .output_trigger(trig),
      .scenario_state(st), .counter_out(cnt), .miss_count(miss)
   );
   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   task automatic chk_all(input string name, input int s, input int t, input int c, input int m);
      chk({name, ".state"}, 32'(st), s);
      chk({name, ".trig"}, 32'(trig), t);
      chk({name, ".cnt"}, 32'(cnt), c);
      chk({name, ".miss"}, 32'(miss), m);
   endtask
   // free-running phase reference: period 24, high for 12
   initial begin
      ph_gen = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (ph_en) begin
            ph_t = (ph_t + 1) % 24;
            ph_gen = ph_t < 12;
            if (ph_t == 0) ph_rise_cyc = cyc;
         end else begin
            ph_t = 23;
            ph_gen = 1'b0;
         end
      end
   end
   task automatic shot(input int idx);
      int n;
      fg = 1'b1;
      step(4);
      fg = 1'b0;
      n = 0;
      while (trig !== 1'b1 && n < 400) begin step(); n++; end
      chk($sformatf("shot%0d.trig_seen", idx), 32'(trig), 1);
      chk($sformatf("shot%0d.phase_to_trig", idx), cyc - ph_rise_cyc, 4);
      chk($sformatf("shot%0d.cnt_at_rise", idx), 32'(cnt), idx + 1);
      chk($sformatf("shot%0d.state_at_rise", idx), 32'(st), 4);
      n = 0;
      while (trig === 1'b1 && n < 50) begin step(); n++; end
      chk($sformatf("shot%0d.width", idx), n, 4);
      rdy = 1'b0;
      step(200);
      rdy = 1'b1;
      n = 0;
      while (st == 3'd5 && n < 20) begin step(); n++; end
   endtask
   initial begin
      int n;
      tbl[0]  = '{0, 0, 0, 1,  5, 0, 0, 0, 0};
      tbl[1]  = '{1, 0, 0, 1,  3, 0, 0, 0, 0};
      tbl[2]  = '{0, 0, 0, 1,  1, 1, 0, 0, 0};
      tbl[3]  = '{0, 1, 0, 1,  4, 2, 0, 0, 0};
      tbl[4]  = '{0, 0, 0, 0, 99, 2, 0, 0, 0};
      tbl[5]  = '{0, 0, 0, 0,  1, 3, 0, 0, 0};
      tbl[6]  = '{0, 0, 1, 0, 10, 3, 0, 0, 0};
      tbl[7]  = '{0, 0, 0, 0, 39, 3, 0, 0, 0};
      tbl[8]  = '{0, 0, 0, 0,  1, 1, 0, 0, 1};
      tbl[9]  = '{0, 1, 0, 1,  4, 2, 0, 0, 1};
      tbl[10] = '{0, 0, 0, 1,100, 3, 0, 0, 1};
      tbl[11] = '{0, 0, 1, 1,  3, 3, 0, 0, 1};
      tbl[12] = '{0, 0, 1, 1,  1, 4, 1, 1, 1};
      tbl[13] = '{0, 0, 0, 1,  3, 4, 1, 1, 1};
      tbl[14] = '{0, 0, 0, 1,  1, 5, 0, 1, 1};
      tbl[15] = '{0, 0, 0, 0, 10, 5, 0, 1, 1};
      tbl[16] = '{0, 0, 0, 1,  2, 5, 0, 1, 1};
      tbl[17] = '{0, 0, 0, 1,  1, 1, 0, 1, 1};
      rst = 1'b1; start = 1'b0; fg = 1'b0; ph_man = 1'b0; ph_en = 1'b0; rdy = 1'b1;
      step(3);
      chk_all("reset", 0, 0, 0, 0);
      rst = 1'b0;
      for (int i = 0; i < 18; i++) begin
         start = tbl[i].st[0]; fg = tbl[i].fg[0]; ph_man = tbl[i].ph[0]; rdy = tbl[i].rdy[0];
         step(tbl[i].n);
         chk_all($sformatf("vec%0d", i), tbl[i].s, tbl[i].t, tbl[i].c, tbl[i].m);
      end
      // nominal three-shot run with free-running phase
      rst = 1'b1; step(2); rst = 1'b0; ph_en = 1'b1;
      start = 1'b1; step(4); start = 1'b0;
      chk("nominal.armed", 32'(st), 1);
      for (int i = 0; i < 3; i++) shot(i);
      chk_all("nominal.done", 6, 0, 3, 0);
      // detector never recovers
      start = 1'b1; step(4); start = 1'b0;
      chk_all("restart_from_done", 1, 0, 0, 0);
      fg = 1'b1; step(4); fg = 1'b0;
      n = 0;
      while (trig !== 1'b1 && n < 400) begin step(); n++; end
      chk("norecover.trig_seen", 32'(trig), 1);
      n = 0;
      while (trig === 1'b1 && n < 50) begin step(); n++; end
      chk("norecover.busy", 32'(st), 5);
      rdy = 1'b0;
      n = 0;
      while (st != 3'd7 && n < 1500) begin step(); n++; end
      chk("norecover.timeout_len", n, 1000);
      chk("norecover.fault", 32'(st), 7);
      step(500);
      rdy = 1'b1;
      step(3);
      chk("fault.hold", 32'(st), 7);
      start = 1'b1; step(4); start = 1'b0;
      chk_all("restart_from_fault", 1, 0, 0, 0);
      // spurious start/fg edges during DELAY
      ph_en = 1'b0; ph_man = 1'b0;
      rst = 1'b1; step(2); rst = 1'b0;
      start = 1'b1; step(4); start = 1'b0;
      fg = 1'b1; step(3); fg = 1'b0;
      chk("spurious.pre_delay", 32'(st), 1);
      step();
      chk("spurious.delay_entry", 32'(st), 2);
      n = 0;
      while (st == 3'd2 && n < 200) begin
         start = (n < 30) && (n % 6 < 3);
         fg = (n >= 30) && (n < 42) && (n % 6 < 3);
         step();
         n++;
      end
      start = 1'b0; fg = 1'b0;
      chk("spurious.delay_len", n, 100);
      chk("spurious.window", 32'(st), 3);
      // phase edge one clock too late: window expires first
      step(47);
      ph_man = 1'b1;
      step(3);
      chk_all("late_phase", 1, 0, 0, 1);
      ph_man = 1'b0;
      step(2);
      // phase edge pulse on the last window clock: trigger wins
      fg = 1'b1; step(4); fg = 1'b0;
      n = 0;
      while (st != 3'd3 && n < 200) begin step(); n++; end
      chk("coinc.window", 32'(st), 3);
      step(46);
      ph_man = 1'b1;
      step(3);
      chk_all("coinc.pre", 3, 0, 0, 1);
      step();
      chk_all("coinc.fire", 4, 1, 1, 1);
      ph_man = 1'b0;
      step(2);
      chk("fire.mid", 32'(trig), 1);
      rst = 1'b1;
      step();
      chk_all("reset_mid_fire", 0, 0, 0, 0);
      rst = 1'b0;
      step(3);
      chk_all("after_reset", 0, 0, 0, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end
endmodule
